// File: rtl/playback_addr_gen.sv
// Sample address generator for flash audio playback.
// Ports: clk/rst (sync, active-high); start_addr/end_addr window
//   bounds latched on restart; restart, play (level), advance
//   (strobe), forward, loop_en, step (0 acts as 1); address,
//   running, wrap (pulse), done (level), all registered.
module playback_addr_gen #(
  parameter int ADDR_W = 23,
  parameter int STEP_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] end_addr,
  input  logic              restart,
  input  logic              play,
  input  logic              advance,
  input  logic              forward,
  input  logic              loop_en,
  input  logic [STEP_W-1:0] step,
  output logic [ADDR_W-1:0] address,
  output logic              running,
  output logic              wrap,
  output logic              done
);

  typedef enum logic [1:0] {
    IDLE,
    PLAY,
    PAUSE,
    DONE
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_lo;
  logic [ADDR_W-1:0] r_hi;
  logic              r_run;
  logic              r_wrap;
  logic              r_done;

  logic [ADDR_W-1:0] w_lo;
  logic [ADDR_W-1:0] w_hi;
  logic [ADDR_W:0]   w_s;
  logic [ADDR_W:0]   w_sum;
  logic [ADDR_W:0]   w_diff;
  logic              w_fit_fwd;
  logic              w_fit_rev;
  logic              w_fit;
  logic [ADDR_W-1:0] w_next;
  logic [ADDR_W-1:0] w_edge;

  assign w_lo = (start_addr <= end_addr) ? start_addr : end_addr;
  assign w_hi = (start_addr <= end_addr) ? end_addr : start_addr;

  assign w_s = (step == '0) ? {{ADDR_W{1'b0}}, 1'b1}
                            : {{(ADDR_W+1-STEP_W){1'b0}}, step};

  // Extra top bit: carry on the sum, borrow on the difference.
  assign w_sum  = {1'b0, r_addr} + w_s;
  assign w_diff = {1'b0, r_addr} - w_s;

  assign w_fit_fwd = (w_sum <= {1'b0, r_hi});
  assign w_fit_rev = !w_diff[ADDR_W] &&
                     (w_diff[ADDR_W-1:0] >= r_lo);

  assign w_fit  = forward ? w_fit_fwd : w_fit_rev;
  assign w_next = forward ? w_sum[ADDR_W-1:0]
                          : w_diff[ADDR_W-1:0];
  // Wrap lands on the opposite edge; no remainder carried.
  assign w_edge = forward ? r_lo : r_hi;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_addr  <= '0;
      r_lo    <= '0;
      r_hi    <= '0;
      r_run   <= 1'b0;
      r_wrap  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_wrap <= 1'b0;
      if (restart) begin
        r_lo    <= w_lo;
        r_hi    <= w_hi;
        r_addr  <= forward ? w_lo : w_hi;
        r_done  <= 1'b0;
        r_state <= play ? PLAY : PAUSE;
        r_run   <= play;
      end else begin
        case (r_state)
          PLAY: begin
            if (!play) begin
              r_state <= PAUSE;
              r_run   <= 1'b0;
            end else if (advance) begin
              if (w_fit) begin
                r_addr <= w_next;
              end else if (loop_en) begin
                r_addr <= w_edge;
                r_wrap <= 1'b1;
              end else begin
                r_state <= DONE;
                r_run   <= 1'b0;
                r_done  <= 1'b1;
              end
            end
          end
          PAUSE: begin
            if (play) begin
              r_state <= PLAY;
              r_run   <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign address = r_addr;
  assign running = r_run;
  assign wrap    = r_wrap;
  assign done    = r_done;

endmodule

// File: tb/tb_playback_addr_gen.sv
// Scoreboard bench for playback_addr_gen: a behavioural model
// queues expected outputs per cycle, checked after each edge.
module tb_playback_addr_gen;

  localparam int AW = 23;
  localparam int SW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] start_addr = '0;
  logic [AW-1:0] end_addr = '0;
  logic          restart = 1'b0;
  logic          play = 1'b0;
  logic          advance = 1'b0;
  logic          forward = 1'b1;
  logic          loop_en = 1'b0;
  logic [SW-1:0] step = '0;
  logic [AW-1:0] address;
  logic          running;
  logic          wrap;
  logic          done;

  playback_addr_gen #(.ADDR_W(AW), .STEP_W(SW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start_addr(start_addr),
    .end_addr  (end_addr),
    .restart   (restart),
    .play      (play),
    .advance   (advance),
    .forward   (forward),
    .loop_en   (loop_en),
    .step      (step),
    .address   (address),
    .running   (running),
    .wrap      (wrap),
    .done      (done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic          run;
    logic          wr;
    logic          dn;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(string tag, longint act, longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0d want %0d",
               tag, $time, act, exp);
    end
  endtask

  // Reference model in plain integer arithmetic.
  localparam int S_IDLE = 0, S_PLAY = 1, S_PAUSE = 2, S_DONE = 3;
  longint m_addr = 0, m_lo = 0, m_hi = 0;
  int     m_st = S_IDLE;
  bit     m_wrap = 0, m_done = 0;

  function automatic void model();
    longint n, s;
    m_wrap = 0;
    if (rst) begin
      m_addr = 0; m_lo = 0; m_hi = 0;
      m_st = S_IDLE; m_done = 0;
    end else if (restart) begin
      m_lo = (start_addr < end_addr) ? start_addr : end_addr;
      m_hi = (start_addr < end_addr) ? end_addr : start_addr;
      m_addr = forward ? m_lo : m_hi;
      m_done = 0;
      m_st = play ? S_PLAY : S_PAUSE;
    end else if (m_st == S_PLAY) begin
      if (!play) m_st = S_PAUSE;
      else if (advance) begin
        s = (step == 0) ? 1 : longint'(step);
        n = forward ? m_addr + s : m_addr - s;
        if (n >= m_lo && n <= m_hi) m_addr = n;
        else if (loop_en) begin
          m_wrap = 1;
          m_addr = forward ? m_lo : m_hi;
        end else begin
          m_st = S_DONE;
          m_done = 1;
        end
      end
    end else if (m_st == S_PAUSE && play) begin
      m_st = S_PLAY;
    end
  endfunction

  task automatic tick();
    exp_t e;
    model();
    e.addr = m_addr[AW-1:0];
    e.run  = (m_st == S_PLAY);
    e.wr   = m_wrap;
    e.dn   = m_done;
    q.push_back(e);
    @(negedge clk);
  endtask

  task automatic adv(int n);
    repeat (n) begin
      advance = 1'b1;
      tick();
    end
    advance = 1'b0;
  endtask

  task automatic rs(longint a, longint b, bit f);
    start_addr = a[AW-1:0];
    end_addr   = b[AW-1:0];
    forward    = f;
    restart    = 1'b1;
    tick();
    restart    = 1'b0;
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() != 0) begin
      e = q.pop_front();
      chk("address", address, e.addr);
      chk("running", running, e.run);
      chk("wrap", wrap, e.wr);
      chk("done", done, e.dn);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: timeout");
    $fatal(1, "timeout");
  end

  initial begin
    @(negedge clk);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    // IDLE ignores advance and play
    play = 1'b1;
    adv(2);
    // forward loop, step 1
    step = 1; loop_en = 1'b1;
    rs(100, 103, 1'b1);
    adv(4);
    tick();
    // one-shot, step 3
    loop_en = 1'b0; step = 3;
    rs(100, 103, 1'b1);
    adv(2);
    adv(2);
    tick();
    // swapped bounds, reverse, step 0
    loop_en = 1'b1; step = 0;
    rs(200, 50, 1'b0);
    adv(151);
    tick();
    // reach 150 then pause with same-cycle advance
    adv(50);
    play = 1'b0;
    adv(1);
    adv(2);
    play = 1'b1;
    tick();
    step = 5;
    adv(1);
    // direction change mid-window
    forward = 1'b1;
    adv(2);
    // restart with simultaneous advance
    advance = 1'b1;
    rs(400, 300, 1'b1);
    advance = 1'b0;
    adv(2);
    // reset mid-play
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    // single-address window
    step = 1; loop_en = 1'b1;
    rs(7, 7, 1'b1);
    adv(3);
    loop_en = 1'b0;
    adv(1);
    adv(1);
    // top of range forward
    step = 15; loop_en = 1'b1;
    rs((1 << AW) - 16, (1 << AW) - 1, 1'b1);
    adv(3);
    loop_en = 1'b0;
    adv(2);
    tick();
    // restart while paused enters PAUSE
    play = 1'b0;
    rs(10, 20, 1'b0);
    adv(1);
    play = 1'b1;
    tick();
    adv(2);
    tick();
    tick();
    @(posedge clk);
    #2;
    chk("drain", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
